// File: rtl/tank_key_decoder_if.sv
// Bundle of the keyboard-side inputs and per-tank heading outputs of the
// tank key decoder. The master side drives frame_tick and the key slots;
// the slave side (the decoder) drives headings, moving flags and strobes.
// Protocol: there is no valid/ready pair; frame_tick is a level marker and
// only its low-to-high transition is significant. Key slots are sampled
// only on the clock edge where that transition is seen.
interface tank_key_decoder_if;
    logic       frame_tick;
    logic [7:0] keycode1;
    logic [7:0] keycode2;
    logic [7:0] keycode3;
    logic [7:0] keycode4;
    logic [1:0] tank1_dir;
    logic       tank1_moving;
    logic       tank1_anim_step;
    logic [1:0] tank2_dir;
    logic       tank2_moving;
    logic       tank2_anim_step;
    // Debug view of each tank FSM state (0 = IDLE, 1 = MOVING)
    logic       tank1_fsm_state;
    logic       tank2_fsm_state;

    modport master (
        output frame_tick, keycode1, keycode2, keycode3, keycode4,
        input  tank1_dir, tank1_moving, tank1_anim_step,
        input  tank2_dir, tank2_moving, tank2_anim_step,
        input  tank1_fsm_state, tank2_fsm_state
    );

    modport slave (
        input  frame_tick, keycode1, keycode2, keycode3, keycode4,
        output tank1_dir, tank1_moving, tank1_anim_step,
        output tank2_dir, tank2_moving, tank2_anim_step,
        output tank1_fsm_state, tank2_fsm_state
    );
endinterface

// File: rtl/tank_key_decoder.sv
// Tank key decoder: once per frame event, resolves a heading per tank from
// the four USB key slots (first matching slot wins), tracks a moving flag,
// and emits a registered one-cycle animation strobe every ANIM_DIV frames
// while a tank keeps moving in the same direction. A new direction or a
// start from idle pulses immediately and restarts the frame count.
module tank_key_decoder #(
    parameter int         ANIM_DIV = 8,
    parameter logic [7:0] T1_UP    = 8'h1A,
    parameter logic [7:0] T1_RIGHT = 8'h07,
    parameter logic [7:0] T1_DOWN  = 8'h16,
    parameter logic [7:0] T1_LEFT  = 8'h04,
    parameter logic [7:0] T2_UP    = 8'd82,
    parameter logic [7:0] T2_RIGHT = 8'd79,
    parameter logic [7:0] T2_DOWN  = 8'd81,
    parameter logic [7:0] T2_LEFT  = 8'd80
) (
    input logic               keydec_clock,
    input logic               keydec_reset,
    tank_key_decoder_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        MOVING = 1'b1
    } state_e;

    localparam logic [7:0] WRAP = 8'(ANIM_DIV - 1);

    logic       frame_tick_q;
    logic       fev;
    logic [7:0] keys [4];
    logic       hit  [2];
    logic [1:0] cand [2];

    state_e     state_q [2];
    state_e     state_d [2];
    logic [1:0] dir_q   [2];
    logic [1:0] dir_d   [2];
    logic [7:0] cnt_q   [2];
    logic [7:0] cnt_d   [2];
    logic       step_q  [2];
    logic       step_d  [2];

    // Scan slots in order; the first slot carrying one of this tank's codes
    // decides the heading, so opposing or duplicate keys resolve by slot.
    function automatic logic [2:0] resolve(
        input logic [7:0] k0, input logic [7:0] k1,
        input logic [7:0] k2, input logic [7:0] k3,
        input logic [7:0] c_up, input logic [7:0] c_right,
        input logic [7:0] c_down, input logic [7:0] c_left
    );
        logic [7:0] k [4];
        logic       h;
        logic [1:0] d;
        k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
        h = 1'b0;
        d = 2'd0;
        for (int s = 0; s < 4; s++) begin
            if (!h) begin
                if (k[s] == c_up)         begin h = 1'b1; d = 2'd0; end
                else if (k[s] == c_right) begin h = 1'b1; d = 2'd1; end
                else if (k[s] == c_down)  begin h = 1'b1; d = 2'd2; end
                else if (k[s] == c_left)  begin h = 1'b1; d = 2'd3; end
            end
        end
        return {h, d};
    endfunction

    assign fev = bus.frame_tick & ~frame_tick_q;

    // Key resolution for both tanks, independent of each other
    always_comb begin
        keys[0] = bus.keycode1;
        keys[1] = bus.keycode2;
        keys[2] = bus.keycode3;
        keys[3] = bus.keycode4;
        {hit[0], cand[0]} = resolve(keys[0], keys[1], keys[2], keys[3],
                                    T1_UP, T1_RIGHT, T1_DOWN, T1_LEFT);
        {hit[1], cand[1]} = resolve(keys[0], keys[1], keys[2], keys[3],
                                    T2_UP, T2_RIGHT, T2_DOWN, T2_LEFT);
    end

    // Per-tank next-state, heading, frame counter and strobe, only on fev
    always_comb begin
        for (int t = 0; t < 2; t++) begin
            state_d[t] = state_q[t];
            dir_d[t]   = dir_q[t];
            cnt_d[t]   = cnt_q[t];
            step_d[t]  = 1'b0;
            if (fev) begin
                case (state_q[t])
                    IDLE: begin
                        cnt_d[t] = 8'd0;
                        if (hit[t]) begin
                            state_d[t] = MOVING;
                            dir_d[t]   = cand[t];
                            step_d[t]  = 1'b1;
                        end
                    end
                    MOVING: begin
                        if (!hit[t]) begin
                            state_d[t] = IDLE;
                            cnt_d[t]   = 8'd0;
                        end else if (cand[t] != dir_q[t]) begin
                            dir_d[t]  = cand[t];
                            cnt_d[t]  = 8'd0;
                            step_d[t] = 1'b1;
                        end else if (cnt_q[t] == WRAP) begin
                            cnt_d[t]  = 8'd0;
                            step_d[t] = 1'b1;
                        end else begin
                            cnt_d[t] = cnt_q[t] + 8'd1;
                        end
                    end
                    default: begin
                        state_d[t] = IDLE;
                        cnt_d[t]   = 8'd0;
                    end
                endcase
            end
        end
    end

    // State registers; reset also kills a strobe already in flight
    always_ff @(posedge keydec_clock or posedge keydec_reset) begin
        if (keydec_reset) begin
            frame_tick_q <= 1'b0;
            for (int t = 0; t < 2; t++) begin
                state_q[t] <= IDLE;
                dir_q[t]   <= 2'd0;
                cnt_q[t]   <= 8'd0;
                step_q[t]  <= 1'b0;
            end
        end else begin
            frame_tick_q <= bus.frame_tick;
            for (int t = 0; t < 2; t++) begin
                state_q[t] <= state_d[t];
                dir_q[t]   <= dir_d[t];
                cnt_q[t]   <= cnt_d[t];
                step_q[t]  <= step_d[t];
            end
        end
    end

    assign bus.tank1_dir       = dir_q[0];
    assign bus.tank1_moving    = (state_q[0] == MOVING);
    assign bus.tank1_anim_step = step_q[0];
    assign bus.tank2_dir       = dir_q[1];
    assign bus.tank2_moving    = (state_q[1] == MOVING);
    assign bus.tank2_anim_step = step_q[1];
    assign bus.tank1_fsm_state = state_q[0];
    assign bus.tank2_fsm_state = state_q[1];

endmodule

// File: tb/tb_tank_key_decoder.sv
// Directed bench for tank_key_decoder with ANIM_DIV = 8.
module tb_tank_key_decoder;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    tank_key_decoder_if kif();

    tank_key_decoder #(.ANIM_DIV(8)) dut (
        .keydec_clock (clk),
        .keydec_reset (rst),
        .bus          (kif.slave)
    );

    task automatic set_keys(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        kif.keycode1 = a;
        kif.keycode2 = b;
        kif.keycode3 = c;
        kif.keycode4 = d;
    endtask

    // One-cycle frame_tick pulse; returns the strobes seen in the cycle after
    // the event edge and the OR of both strobes one cycle later.
    task automatic frame_event(output logic s1, output logic s2, output logic late);
        @(negedge clk);
        kif.frame_tick = 1'b1;
        @(negedge clk);
        s1 = kif.tank1_anim_step;
        s2 = kif.tank2_anim_step;
        kif.frame_tick = 1'b0;
        @(negedge clk);
        late = kif.tank1_anim_step | kif.tank2_anim_step;
    endtask

    task automatic test_reset();
        logic s1, s2, late;
        rst = 1'b1;
        kif.frame_tick = 1'b0;
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        n_checks++;
        if ({kif.tank1_dir, kif.tank1_moving, kif.tank1_anim_step,
             kif.tank2_dir, kif.tank2_moving, kif.tank2_anim_step} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: got t1=%0d/%0b/%0b t2=%0d/%0b/%0b, want all 0",
                     kif.tank1_dir, kif.tank1_moving, kif.tank1_anim_step,
                     kif.tank2_dir, kif.tank2_moving, kif.tank2_anim_step);
        end
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            frame_event(s1, s2, late);
            n_checks++;
            if ({s1, s2, late, kif.tank1_moving, kif.tank2_moving,
                 kif.tank1_dir, kif.tank2_dir} !== 9'b0) begin
                n_fail++;
                $display("FAIL empty_keys ev%0d: got s=%b%b late=%b mv=%b%b dir=%0d/%0d, want all 0",
                         i, s1, s2, late, kif.tank1_moving, kif.tank2_moving,
                         kif.tank1_dir, kif.tank2_dir);
            end
        end
    endtask

    task automatic test_hold_div();
        logic s1, s2, late, exp1;
        set_keys(8'h00, 8'h07, 8'h00, 8'h00);
        for (int i = 1; i <= 17; i++) begin
            frame_event(s1, s2, late);
            exp1 = (i == 1) || (i == 9) || (i == 17);
            n_checks++;
            if (s1 !== exp1 || s2 !== 1'b0 || late !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_div ev%0d: got s1=%b s2=%b late=%b, want s1=%b s2=0 late=0",
                         i, s1, s2, late, exp1);
            end
        end
        n_checks++;
        if (kif.tank1_dir !== 2'd1 || kif.tank1_moving !== 1'b1 ||
            kif.tank1_fsm_state !== 1'b1 || kif.tank2_moving !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_div_state: got dir=%0d mv=%b st=%b t2mv=%b, want 1/1/1/0",
                     kif.tank1_dir, kif.tank1_moving, kif.tank1_fsm_state, kif.tank2_moving);
        end
    endtask

    task automatic test_priority();
        logic s1, s2, late;
        set_keys(8'h04, 8'h00, 8'h07, 8'h00);
        frame_event(s1, s2, late);
        n_checks++;
        if (kif.tank1_dir !== 2'd3 || s1 !== 1'b1) begin
            n_fail++;
            $display("FAIL slot_priority: got dir=%0d s1=%b, want dir=3 s1=1", kif.tank1_dir, s1);
        end
        set_keys(8'h00, 8'h00, 8'h07, 8'h00);
        frame_event(s1, s2, late);
        n_checks++;
        if (kif.tank1_dir !== 2'd1 || s1 !== 1'b1) begin
            n_fail++;
            $display("FAIL turn_pulse: got dir=%0d s1=%b, want dir=1 s1=1", kif.tank1_dir, s1);
        end
        for (int i = 1; i <= 8; i++) begin
            frame_event(s1, s2, late);
            n_checks++;
            if (s1 !== (i == 8) || kif.tank1_dir !== 2'd1) begin
                n_fail++;
                $display("FAIL count_restart ev%0d: got s1=%b dir=%0d, want s1=%b dir=1",
                         i, s1, kif.tank1_dir, (i == 8));
            end
        end
    endtask

    task automatic test_two_tanks();
        logic s1, s2, late;
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        frame_event(s1, s2, late);
        n_checks++;
        if (kif.tank1_moving !== 1'b0 || kif.tank1_dir !== 2'd1 || s1 !== 1'b0) begin
            n_fail++;
            $display("FAIL release_t1: got mv=%b dir=%0d s1=%b, want 0/1/0",
                     kif.tank1_moving, kif.tank1_dir, s1);
        end
        set_keys(8'h1A, 8'd81, 8'h00, 8'h00);
        frame_event(s1, s2, late);
        n_checks++;
        if (s1 !== 1'b1 || s2 !== 1'b1 || kif.tank1_dir !== 2'd0 || kif.tank2_dir !== 2'd2 ||
            kif.tank1_moving !== 1'b1 || kif.tank2_moving !== 1'b1 || late !== 1'b0) begin
            n_fail++;
            $display("FAIL both_tanks: got s=%b%b late=%b dir=%0d/%0d mv=%b%b, want s=11 late=0 dir=0/2 mv=11",
                     s1, s2, late, kif.tank1_dir, kif.tank2_dir, kif.tank1_moving, kif.tank2_moving);
        end
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        frame_event(s1, s2, late);
        n_checks++;
        if (s1 !== 1'b0 || s2 !== 1'b0 || kif.tank1_dir !== 2'd0 || kif.tank2_dir !== 2'd2 ||
            kif.tank1_moving !== 1'b0 || kif.tank2_moving !== 1'b0) begin
            n_fail++;
            $display("FAIL both_release: got s=%b%b dir=%0d/%0d mv=%b%b, want s=00 dir=0/2 mv=00",
                     s1, s2, kif.tank1_dir, kif.tank2_dir, kif.tank1_moving, kif.tank2_moving);
        end
    endtask

    task automatic test_tick_held();
        logic s1, s2, late;
        int   pulses;
        pulses = 0;
        set_keys(8'h07, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        kif.frame_tick = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (kif.tank1_anim_step === 1'b1) pulses++;
        end
        kif.frame_tick = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pulses !== 1 || kif.tank1_dir !== 2'd1 || kif.tank1_moving !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_held: got pulses=%0d dir=%0d mv=%b, want 1/1/1",
                     pulses, kif.tank1_dir, kif.tank1_moving);
        end
        set_keys(8'h04, 8'd82, 8'h00, 8'h00);
        repeat (5) @(negedge clk);
        n_checks++;
        if (kif.tank1_dir !== 2'd1 || kif.tank2_moving !== 1'b0 ||
            kif.tank1_anim_step !== 1'b0 || kif.tank2_anim_step !== 1'b0) begin
            n_fail++;
            $display("FAIL keys_between_ticks: got dir=%0d t2mv=%b s=%b%b, want 1/0/00",
                     kif.tank1_dir, kif.tank2_moving, kif.tank1_anim_step, kif.tank2_anim_step);
        end
        frame_event(s1, s2, late);
        n_checks++;
        if (s1 !== 1'b1 || s2 !== 1'b1 || kif.tank1_dir !== 2'd3 || kif.tank2_dir !== 2'd0) begin
            n_fail++;
            $display("FAIL next_tick: got s=%b%b dir=%0d/%0d, want s=11 dir=3/0",
                     s1, s2, kif.tank1_dir, kif.tank2_dir);
        end
    endtask

    task automatic test_async_reset();
        logic s1, s2, late;
        set_keys(8'h04, 8'h00, 8'h00, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            frame_event(s1, s2, late);
            n_checks++;
            if (s1 !== 1'b0 || kif.tank1_moving !== 1'b1 || kif.tank2_moving !== 1'b0) begin
                n_fail++;
                $display("FAIL midcount ev%0d: got s1=%b mv=%b t2mv=%b, want 0/1/0",
                         i, s1, kif.tank1_moving, kif.tank2_moving);
            end
        end
        set_keys(8'h07, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        kif.frame_tick = 1'b1;
        @(negedge clk);
        n_checks++;
        if (kif.tank1_anim_step !== 1'b1 || kif.tank1_dir !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset_strobe: got s1=%b dir=%0d, want 1/1",
                     kif.tank1_anim_step, kif.tank1_dir);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({kif.tank1_dir, kif.tank1_moving, kif.tank1_anim_step,
             kif.tank2_dir, kif.tank2_moving, kif.tank2_anim_step} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got t1=%0d/%0b/%0b t2=%0d/%0b/%0b, want all 0",
                     kif.tank1_dir, kif.tank1_moving, kif.tank1_anim_step,
                     kif.tank2_dir, kif.tank2_moving, kif.tank2_anim_step);
        end
        kif.frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        frame_event(s1, s2, late);
        n_checks++;
        if (s1 !== 1'b1 || kif.tank1_dir !== 2'd1 || kif.tank1_moving !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_start: got s1=%b dir=%0d mv=%b, want 1/1/1",
                     s1, kif.tank1_dir, kif.tank1_moving);
        end
        for (int i = 1; i <= 8; i++) begin
            frame_event(s1, s2, late);
            n_checks++;
            if (s1 !== (i == 8)) begin
                n_fail++;
                $display("FAIL post_reset_count ev%0d: got s1=%b, want %b", i, s1, (i == 8));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        kif.frame_tick = 1'b0;
        set_keys(8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_hold_div();
        test_priority();
        test_two_tanks();
        test_tick_held();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tank_key_decoder.md
Name: tank_key_decoder

Overview:
Upstream input stage for the two tank animators and the tank motion logic. It samples the four USB keycode slots once per video frame and resolves one heading per tank, plus a moving flag. It also emits a one-cycle animation-step strobe at a programmable frame rate. Downstream animators advance their tread frame on this strobe, so they no longer toggle on every clock while a key is held.

Parameters:
ANIM_DIV, 8, frames per animation step while moving (legal range 1..255)
T1_UP / T1_RIGHT / T1_DOWN / T1_LEFT, 8'h1A / 8'h07 / 8'h16 / 8'h04, tank 1 key codes (W/D/S/A)
T2_UP / T2_RIGHT / T2_DOWN / T2_LEFT, 8'd82 / 8'd79 / 8'd81 / 8'd80, tank 2 key codes (arrow keys)

Ports:
keydec_clock  in  1  system clock; all state changes on its rising edge
keydec_reset  in  1  asynchronous, active-high reset
frame_tick  in  1  frame marker (vsync-derived), may be high for any number of cycles
keycode1..keycode4  in  8 each  USB HID key slots; 8'h00 = empty slot
tank1_dir  out  2  tank 1 heading: 0 up, 1 right, 2 down, 3 left
tank1_moving  out  1  tank 1 has a direction key held as of the last frame event
tank1_anim_step  out  1  one-cycle strobe: advance tank 1 tread frame
tank2_dir, tank2_moving, tank2_anim_step  out  2/1/1  same meanings for tank 2

Behaviour:
- Reset (async, active-high): every tankN_dir = 0 (up), tankN_moving = 0, tankN_anim_step = 0. Internal state is cleared: both frame counters = 0, both FSMs in IDLE, frame_tick history register = 0. Reset asserted mid-operation overrides everything immediately, including a strobe that is in flight.
- Frame event: fev = frame_tick & ~frame_tick_q, where frame_tick_q is frame_tick registered each clock. Exactly one event per low-to-high transition. A tick held high for N cycles counts once.
- All state below updates only at an edge where fev = 1. Keycodes are sampled at that edge only; key changes between events are ignored.
- Per-tank key resolution (tanks are independent; a slot may match only its own tank's codes):
  - Scan slots in order keycode1, keycode2, keycode3, keycode4. The first slot matching one of the tank's four codes sets the candidate heading.
  - hit = 1 if any slot matches.
  - Duplicate or opposing keys resolve purely by slot order.
  - Unknown codes and 8'h00 are ignored.
- Per-tank FSM, states IDLE and MOVING, evaluated at fev:
  - IDLE, hit = 0: stay IDLE; dir held; counter stays 0.
  - IDLE, hit = 1: go to MOVING; dir <= candidate; moving <= 1; counter <= 0; pulse anim_step.
  - MOVING, hit = 0: go to IDLE; moving <= 0; dir held at its last value; counter <= 0; no pulse.
  - MOVING, hit = 1, candidate != dir: dir <= candidate; counter <= 0; pulse anim_step.
  - MOVING, hit = 1, candidate == dir: if counter == ANIM_DIV-1, then counter <= 0 and pulse anim_step; else counter <= counter+1 with no pulse.
- ANIM_DIV = 1: pulse on every frame event while moving.
- Counter width is 8 bits. The wrap value is ANIM_DIV-1; the counter never exceeds it.
- Strobe timing: anim_step is registered. It is high for exactly the one clock cycle following the fev edge, and low at all other times. tankN_dir and tankN_moving change on that same edge (latency: 1 edge after frame_tick rises).
- Both tanks may pulse in the same cycle.

Test Plan:
- Reset, then 3 frame events with all slots 00 → dir=0, moving=0, no anim_step on either tank.
- keycode2=8'h07 held, ANIM_DIV=8, 17 frame events → tank1_dir=1, moving=1. anim_step pulses on events 1, 9, 17 (each one cycle wide); tank 2 stays idle.
- keycode1=8'h04, keycode3=8'h07 together → tank1_dir=3 (slot 1 wins). Clear keycode1 at the next event → dir=1, immediate pulse, counter restarts.
- keycode1=8'h1A, keycode2=8'd81 → tank1_dir=0 and tank2_dir=2, both moving, both strobes in the same cycle. Release all → both moving=0, headings held at 0 and 2.
- frame_tick held high 20 cycles with a key pressed → one frame event only. Key changes between ticks do not alter outputs.
- Assert keydec_reset asynchronously (between clock edges) while MOVING, mid-count → all outputs 0 immediately. After release, the first event with a key held pulses anim_step.
